// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory/IO bus controller sitting directly behind the CPU core.
//
// It accepts one CPU request at a time and decodes the byte address into one
// of four targets:
//   - on-chip synchronous RAM (addr[31:12] == 0),
//   - LED register (0xE000_0000),
//   - switch inputs (0xF000_0000, read-only),
//   - free-running counter (0xF000_0004).
// Each access is held for a region-dependent number of wait cycles.
// mio_ready pulses for exactly one cycle when the access completes.
//
// Optional build macro MIO_BUS_ERR_EN adds the following:
//   - a bus_err output, pulsed with mio_ready on unmapped accesses,
//   - a read-only fault-address register at 0xF000_0008.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active-low
//   cpu_mio    CPU request, held until mio_ready is seen
//   mem_w      write qualifier, valid while cpu_mio = 1
//   addr_in    CPU byte address (bits [1:0] ignored)
//   wdata      CPU write data
//   rdata      registered read data, held until the next read completes
//   mio_ready  one-cycle access-complete pulse
//   ram_addr   RAM word address (registered at acceptance)
//   ram_we     RAM write enable, high for the first ACCESS cycle of a write
//   ram_din    RAM write data (latched CPU write data)
//   ram_dout   RAM read data, one cycle after ram_addr
//   led        LED register
//   sw         switch inputs
//   bus_err    unmapped-access flag (MIO_BUS_ERR_EN only)
module mio_bus_ctrl #(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [7:0]        led,
  input  logic [7:0]        sw
`ifdef MIO_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [2:0] {RG_RAM, RG_LED, RG_SW, RG_CNT, RG_ERR, RG_NONE} region_t;

  localparam logic [3:0] RAM_WAIT_M1 = 4'(RAM_WAIT - 1);

  state_t      state, state_nxt;
  region_t     region_in, region_q;
  logic [3:0]  wait_cnt;
  logic        issue;
  logic        we_q;
  logic        ram_we_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt;
  logic [31:0] rd_mux;
  logic        accept;
  logic        finish;
  logic        unused_addr_bits;

`ifdef MIO_BUS_ERR_EN
  logic [31:0] addr_q;
  logic [31:0] err_addr;
`endif

  function automatic region_t decode(input logic [31:0] a);
    region_t r;
    r = RG_NONE;
    if (a[31:12] == 20'h0)              r = RG_RAM;
    else if (a[31:2] == 30'h3800_0000)  r = RG_LED;
    else if (a[31:2] == 30'h3C00_0000)  r = RG_SW;
    else if (a[31:2] == 30'h3C00_0001)  r = RG_CNT;
`ifdef MIO_BUS_ERR_EN
    else if (a[31:2] == 30'h3C00_0002)  r = RG_ERR;
`endif
    return r;
  endfunction

  assign unused_addr_bits = ^addr_in[1:0];

  assign region_in = decode(addr_in);
  assign accept    = (state == IDLE) && cpu_mio;
  // The first ACCESS cycle only issues the access (address/strobe to the RAM).
  // The wait count runs after it, giving W + 1 cycles from acceptance to DONE.
  assign finish    = (state == ACCESS) && !issue && (wait_cnt == 4'd0);

  assign mio_ready = (state == DONE);
  assign ram_din   = wdata_q;
  // Gate with reset so a write strobe cannot reach the RAM on an edge where
  // reset is asserted; an abandoned write is then never issued.
  assign ram_we    = ram_we_q & reset;

`ifdef MIO_BUS_ERR_EN
  assign bus_err = (state == DONE) && (region_q == RG_NONE);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_mio) state_nxt = ACCESS;
      ACCESS:  if (finish)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    case (region_q)
      RG_RAM:  rd_mux = ram_dout;
      RG_LED:  rd_mux = {24'h0, led};
      RG_SW:   rd_mux = {24'h0, sw};
      RG_CNT:  rd_mux = cnt;
`ifdef MIO_BUS_ERR_EN
      RG_ERR:  rd_mux = err_addr;
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      region_q <= RG_NONE;
      wait_cnt <= 4'd0;
      issue    <= 1'b0;
      we_q     <= 1'b0;
      ram_we_q <= 1'b0;
      wdata_q  <= 32'h0;
      ram_addr <= '0;
      rdata    <= 32'h0;
      led      <= 8'h0;
      cnt      <= 32'h0;
`ifdef MIO_BUS_ERR_EN
      addr_q   <= 32'h0;
      err_addr <= 32'h0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt + 32'd1;
      ram_we_q <= accept && (region_in == RG_RAM) && mem_w;

      // acceptance: latch the request
      if (accept) begin
        region_q <= region_in;
        we_q     <= mem_w;
        wdata_q  <= wdata;
        ram_addr <= addr_in[RAM_AW+1:2];
        wait_cnt <= (region_in == RG_RAM) ? RAM_WAIT_M1 : 4'd0;
        issue    <= 1'b1;
`ifdef MIO_BUS_ERR_EN
        addr_q   <= addr_in;
`endif
      end else if (state == ACCESS) begin
        if (issue)
          issue <= 1'b0;
        else if (wait_cnt != 4'd0)
          wait_cnt <= wait_cnt - 4'd1;
      end

      // completion: ACCESS -> DONE edge
      if (finish) begin
        if (we_q) begin
          if (region_q == RG_LED) led <= wdata_q[7:0];
          // Overrides the increment above on this edge.
          if (region_q == RG_CNT) cnt <= wdata_q;
        end else begin
          rdata <= rd_mux;
        end
`ifdef MIO_BUS_ERR_EN
        if (region_q == RG_NONE) err_addr <= addr_q;
`endif
      end
    end
  end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the multi-cycle CPU core.
- Accepts one CPU bus request at a time and decodes the address to on-chip RAM, an LED register, a switch input or a free-running counter.
- Inserts wait states per region, returns read data and pulses mio_ready for exactly one cycle per completed access.

Parameters:
- RAM_WAIT, 2, ACCESS cycles for RAM accesses; legal range 1..15.
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW words).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- cpu_mio  in  1  CPU request; held high until the cycle mio_ready is seen.
- mem_w  in  1  write qualifier, level-valid while cpu_mio=1 (ungated write strobe).
- addr_in  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  CPU write data.
- rdata  out  32  registered read data to CPU.
- mio_ready  out  1  access-complete pulse.
- ram_addr  out  RAM_AW  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  synchronous RAM read data (1-cycle latency).
- led  out  8  LED register.
- sw  in  8  switch inputs.

Behaviour:
- Address map:
  - RAM: addr_in[31:12]==0, word index addr[RAM_AW+1:2]. Accesses wrap within RAM.
  - LED: 0xE000_0000, read/write, bits [7:0]; upper bits read 0.
  - SW: 0xF000_0000, read-only {24'b0, sw}; writes ignored.
  - CNT: 0xF000_0004, read/write 32-bit counter.
  - Anything else is unmapped.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS when cpu_mio=1. On that edge, latch addr_in, wdata and mem_w, and load the wait counter with W-1.
  - W = RAM_WAIT for RAM; W = 1 for LED, SW, CNT and unmapped.
  - ACCESS: decrement the wait counter. At 0, go to DONE.
  - DONE: mio_ready=1 for this single cycle, then IDLE unconditionally.
  - A cpu_mio still high in the following IDLE cycle starts a new access.
- Latency: with acceptance on edge E0, mio_ready is high between edges E0+W+1 and E0+W+2. With the default RAM_WAIT, a RAM access has ready 3 cycles after acceptance.
- RAM:
  - ram_addr is registered from the latched address on the acceptance edge and held until the next acceptance.
  - Write: ram_we=1 for exactly the first ACCESS cycle, ram_din = latched wdata.
  - Read: ram_dout is captured into rdata on the ACCESS->DONE edge.
- Register access completes on the ACCESS->DONE edge:
  - LED write: led <= wdata[7:0].
  - CNT write: counter <= wdata. The counter increments from the loaded value on the following cycles; the write wins over the increment on that edge.
  - SW read: captures sw on that edge.
  - CNT read: captures the pre-increment value on that edge.
- Counter: increments by 1 every cycle outside reset and wraps 0xFFFF_FFFF -> 0.
- Unmapped: reads return 0; writes have no effect.
- rdata is held from DONE until the next read completes. Writes do not modify rdata.
- cpu_mio or mem_w changing during ACCESS or DONE is ignored; latched values are used.
- Reset values (reset=0 on any edge, including mid-access): state IDLE, mio_ready 0, rdata 0, ram_we 0, ram_addr 0, ram_din 0, led 0, counter 0.
  - A pending access is abandoned.
  - A RAM write not yet issued is never issued.

Optional Feature:
- Macro MIO_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit).
  - An unmapped access raises bus_err=1 together with mio_ready in DONE, for that cycle only.
  - The faulting address is latched into an error register, readable at 0xF000_0008; reset value 0.
  - The error register is read-only; writes to it are ignored.
  - 0xF000_0008 is mapped only when the macro is defined.
- Undefined: no bus_err port and no error register; 0xF000_0008 is unmapped (reads 0).

Test Plan:
- Reset hold 3 cycles, then release -> mio_ready=0, rdata=0, led=0, counter reads 0+N where N = cycles since release (check exact value).
- RAM write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ram_we pulses 1 cycle with ram_addr=4; read gives rdata=0xDEADBEEF; mio_ready rises 3 cycles after each acceptance.
- Write 0x1A5 to 0xE000_0000 -> led=0xA5; readback rdata=0x0000_00A5. Read 0xF000_0000 with sw=0x3C -> rdata=0x0000_003C, ready 2 cycles after acceptance.
- Write 0xFFFF_FFFE to CNT, wait 2 cycles after DONE, read CNT -> value wrapped through 0 with the exact expected count; no missed or double increment.
- Assert reset during ACCESS of a RAM write -> ram_we never asserts (RAM_WAIT=2, reset on acceptance edge+1), state IDLE, no mio_ready.
- Read 0x8000_0000 -> rdata=0. With MIO_BUS_ERR_EN, bus_err=1 for 1 cycle and a read of 0xF000_0008 returns 0x8000_0000.
